// File: rtl/fpu_wb_ctrl.sv
// fpu_wb_ctrl: Wishbone-slave register file that sequences FPU reset/act and captures result and flags
module fpu_wb_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int RST_CYCLES = 2,
  parameter int CMP_LAT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [31:0] fpu_in1_o,
  output logic [31:0] fpu_in2_o,
  output logic [2:0]  fpu_opcode_o,
  output logic [2:0]  fpu_round_o,
  output logic        fpu_rst_o,
  output logic        fpu_act_o,
  input  logic [31:0] fpu_out_i,
  input  logic [8:0]  fpu_flags_i,
  output logic        irq_o
);
  localparam int CW = $clog2(TIMEOUT + RST_CYCLES + CMP_LAT + 1);
  localparam logic [CW-1:0] R_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CMP_LAT - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [1:0] IDLE = 2'd0, CLEAR = 2'd1, RUN = 2'd2, CAPTURE = 2'd3;
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [31:0] opa, opb, result, rdata, opa_w, opb_w, ctrl_w;
  logic [5:0] ctrl;
  logic [7:0] flags;
  logic done, timeout, cmd_err, rst_hold, busy;
  logic req, wr, reg_wr, start, busy_err, op_err, accept, run_exit, w1c_ok;
  logic [2:0] a;
  logic unused;
  function automatic logic [31:0] merge(input logic [31:0] o, n, input logic [3:0] s);
    for (int i = 0; i < 4; i++) merge[8*i+:8] = s[i] ? n[8*i+:8] : o[8*i+:8];
  endfunction
  assign unused = ^{wbs_adr_i[1:0], ctrl_w[31:6]};
  assign fpu_in1_o = opa;
  assign fpu_in2_o = opb;
  assign fpu_opcode_o = ctrl[2:0];
  assign fpu_round_o = ctrl[5:3];
  // rst_hold keeps the FPU in reset through the bus reset cycle itself
  assign fpu_rst_o = rst_hold | (state == CLEAR);
  assign fpu_act_o = state == RUN;
  assign irq_o = done;
  always_comb begin
    a = wbs_adr_i[4:2];
    busy = state != IDLE;
    req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]) & ~wbs_ack_o;
    wr = req & wbs_we_i;
    opa_w = merge(opa, wbs_dat_i, wbs_sel_i);
    opb_w = merge(opb, wbs_dat_i, wbs_sel_i);
    ctrl_w = merge({26'b0, ctrl}, wbs_dat_i, wbs_sel_i);
    reg_wr = wr && a <= 3'd2;
    start = wr && a == 3'd2 && wbs_sel_i[1] && wbs_dat_i[8];
    busy_err = reg_wr && busy;
    op_err = start && !busy && ctrl_w[2:0] > 3'd4;
    accept = start && !busy && ctrl_w[2:0] <= 3'd4;
    w1c_ok = wr && a == 3'd3 && wbs_sel_i[0];
    // done at cnt 0 may be left over from the previous operation
    run_exit = cnt == T_LAST || (ctrl[2:0] == 3'd4 ? cnt == C_LAST : fpu_flags_i[8] && cnt != '0);
    rdata = a == 3'd0 ? opa : a == 3'd1 ? opb : a == 3'd2 ? {26'b0, ctrl} :
            a == 3'd3 ? {20'b0, flags, cmd_err, timeout, done, busy} : a == 3'd4 ? result : 32'b0;
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      cnt <= '0;
      opa <= '0;
      opb <= '0;
      ctrl <= '0;
      result <= '0;
      flags <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
      cmd_err <= 1'b0;
      rst_hold <= 1'b1;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      rst_hold <= 1'b0;
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rdata : 32'b0;
      if (wr && !busy && a == 3'd0) opa <= opa_w;
      if (wr && !busy && a == 3'd1) opb <= opb_w;
      if (wr && !busy && a == 3'd2 && !op_err) ctrl <= ctrl_w[5:0];
      if (busy_err || op_err) cmd_err <= 1'b1;
      else if (w1c_ok && wbs_dat_i[3]) cmd_err <= 1'b0;
      if (state == CAPTURE) done <= 1'b1;
      else if (accept || (w1c_ok && wbs_dat_i[1])) done <= 1'b0;
      if (state == RUN && cnt == T_LAST) timeout <= 1'b1;
      else if (accept || (w1c_ok && wbs_dat_i[2])) timeout <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) state <= CLEAR;
        end
        CLEAR: begin
          cnt <= cnt == R_LAST ? '0 : cnt + 1'b1;
          if (cnt == R_LAST) state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (run_exit) state <= CAPTURE;
        end
        default: begin
          result <= ctrl[2:0] == 3'd4 ? 32'b0 : fpu_out_i;
          flags <= fpu_flags_i[7:0];
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_wb_ctrl.sv
// tb_fpu_wb_ctrl: directed and randomized checks of fpu_wb_ctrl against a behavioural FPU and register model
module tb_fpu_wb_ctrl;
  localparam int RST_CYCLES = 2, CMP_LAT = 2, TIMEOUT = 64;
  localparam logic [31:0] BA = 32'h3000_0000;
  logic clk = 0, rst = 1, stb = 0, cyc = 0, we = 0, ack, f_rst, f_act, irq;
  logic [3:0] sel = 0;
  logic [31:0] dat = 0, adr = 0, dat_o, in1, in2, f_out;
  logic [2:0] f_op, f_rnd;
  logic [8:0] f_flags;
  int vectors = 0, miscompares = 0;
  logic [31:0] m_out = 0;
  logic [7:0] m_flg = 0;
  int m_after = 0, m_cnt = 0, act_n = 0, rst_n = 0;
  fpu_wb_ctrl #(.BASE_ADDR(BA), .RST_CYCLES(RST_CYCLES), .CMP_LAT(CMP_LAT), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .fpu_in1_o(in1), .fpu_in2_o(in2), .fpu_opcode_o(f_op), .fpu_round_o(f_rnd),
    .fpu_rst_o(f_rst), .fpu_act_o(f_act), .fpu_out_i(f_out), .fpu_flags_i(f_flags), .irq_o(irq));
  always #5 clk = ~clk;
  // FPU stand-in: done rises once m_after act cycles have elapsed since its reset
  always @(posedge clk) m_cnt <= f_rst ? 0 : f_act ? m_cnt + 1 : m_cnt;
  always @(posedge clk) begin
    if (f_act) act_n <= act_n + 1;
    if (f_rst) rst_n <= rst_n + 1;
  end
  assign f_out = m_out;
  assign f_flags = {m_after != 0 && m_cnt >= m_after, m_flg};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic bus(input logic w, input logic [31:0] ad, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic got);
    @(posedge clk); #1;
    stb = 1; cyc = 1; we = w; adr = ad; dat = d; sel = s; got = 0; rd = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk); #1;
      if (ack) begin got = 1; rd = dat_o; end
    end
    stb = 0; cyc = 0; we = 0;
  endtask
  task automatic wr(input logic [2:0] r, input logic [31:0] d, input logic [3:0] s = 4'hf);
    logic [31:0] x; logic g;
    bus(1, BA | {27'b0, r, 2'b0}, d, s, x, g);
    if (!g) chk("write_ack", {31'b0, g}, 1);
  endtask
  task automatic rd(input logic [2:0] r, output logic [31:0] d);
    logic g;
    bus(0, BA | {27'b0, r, 2'b0}, 0, 0, d, g);
    if (!g) chk("read_ack", {31'b0, g}, 1);
  endtask
  task automatic wait_irq(input int lim);
    int n = 0;
    while (!irq && n < lim) begin @(posedge clk); #1; n++; end
    if (!irq) chk("irq_timeout", {31'b0, irq}, 1);
  endtask
  task automatic run_op(input logic [2:0] op, input logic [2:0] rnd, input logic [31:0] a_v, input logic [31:0] b_v);
    logic [31:0] v;
    int a0, r0, exp_act;
    logic exp_to;
    exp_to = op != 4 && m_after == 0;
    exp_act = op == 4 ? CMP_LAT : m_after == 0 ? TIMEOUT : m_after + 1;
    wr(0, a_v); wr(1, b_v);
    a0 = act_n; r0 = rst_n;
    wr(2, 32'h100 | {26'b0, rnd, op});
    rd(3, v);
    chk("status_after_start", {29'b0, v[2:0]}, 32'h1);
    wait_irq(300);
    chk("act_cycles", act_n - a0, exp_act);
    chk("rst_cycles", rst_n - r0, RST_CYCLES);
    chk("in1", in1, a_v);
    chk("in2", in2, b_v);
    chk("opcode_round", {26'b0, f_rnd, f_op}, {26'b0, rnd, op});
    rd(4, v);
    chk("result", v, op == 4 ? 32'b0 : m_out);
    rd(3, v);
    chk("status", {v[31:4], v[2:0]}, {20'b0, m_flg, exp_to, 2'b10});
    chk("irq", {31'b0, irq}, 1);
  endtask
  initial begin
    logic [31:0] v;
    logic g;
    int a0, r0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fpu_rst", {31'b0, f_rst}, 1);
    chk("reset_act", {31'b0, f_act}, 0);
    chk("reset_ack_irq", {30'b0, ack, irq}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("fpu_rst_drops", {31'b0, f_rst}, 0);
    for (int r = 0; r < 6; r++) begin
      rd(3'(r), v);
      chk("reset_regs", v, 0);
    end
    m_after = 5; m_out = 32'h4040_0000; m_flg = 8'h00;
    run_op(0, 0, 32'h3F80_0000, 32'h4000_0000);
    m_after = 0; m_out = 32'h1234_5678; m_flg = 8'h08;
    run_op(4, 1, 32'h4000_0000, 32'h4000_0000);
    m_after = 0; m_out = 32'h7FC0_0000; m_flg = 8'h02;
    run_op(2, 2, 32'h3F80_0000, 32'h0);
    m_after = 0;
    wr(2, 32'h102);
    wr(0, 32'hDEAD_BEEF);
    rd(0, v);
    chk("opa_locked", v, 32'h3F80_0000);
    rd(3, v);
    chk("cmd_err_busy", {28'b0, v[3:0]}, 32'h9);
    wait_irq(300);
    rd(3, v);
    chk("timeout_status", {28'b0, v[3:0]}, 32'hE);
    wr(3, 32'h8);
    rd(3, v);
    chk("cmd_err_w1c", {28'b0, v[3:0]}, 32'h6);
    wr(3, 32'h2);
    @(posedge clk); #1;
    chk("done_w1c_irq", {31'b0, irq}, 0);
    a0 = act_n; r0 = rst_n;
    wr(2, 32'h106);
    repeat (10) @(posedge clk);
    #1;
    chk("bad_op_no_act", act_n - a0, 0);
    chk("bad_op_no_rst", rst_n - r0, 0);
    rd(3, v);
    chk("bad_op_status", {31'b0, v[3], v[0]} >> 0, 32'h2);
    rd(2, v);
    chk("bad_op_ctrl_kept", v, 32'h2);
    wr(3, 32'h8);
    rd(5, v);
    chk("unmapped_read", v, 0);
    bus(1, BA + 32'h20, 32'h5555_5555, 4'hf, v, g);
    chk("nomatch_no_ack", {31'b0, g}, 0);
    for (int k = 0; k < 20; k++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 4));
      m_after = op == 4 ? 0 : ($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 20));
      m_out = $urandom;
      m_flg = 8'($urandom);
      run_op(op, 3'($urandom), $urandom, $urandom);
    end
    m_after = 0;
    wr(2, 32'h101);
    for (int n = 0; n < 20 && !f_act; n++) begin @(posedge clk); #1; end
    chk("act_seen", {31'b0, f_act}, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort_act", {31'b0, f_act}, 0);
    chk("abort_fpu_rst", {31'b0, f_rst}, 1);
    rd(3, v);
    chk("abort_status", v, 0);
    wr(0, 32'h1122_3344);
    wr(0, 32'hAABB_CCDD, 4'b0001);
    rd(0, v);
    chk("byte_sel", v, 32'h1122_33DD);
    wr(1, 32'hAABB_CCDD, 4'b1010);
    rd(1, v);
    chk("byte_sel_opb", v, 32'hAA00_CC00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
